// File: rtl/dram_device_model_if.sv
// Raw SDRAM command/data pins between the AXI-to-DRAM wrapper (master)
// and the single-bank device model (slave).
interface dram_device_model_if #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 11
);
    logic                   DRAM_CSn;
    logic                   DRAM_RASn;
    logic                   DRAM_CASn;
    logic [DATA_BITS/8-1:0] DRAM_WEn;
    logic [ADDR_BITS-1:0]   DRAM_A;
    logic [DATA_BITS-1:0]   DRAM_D;
    logic [DATA_BITS-1:0]   DRAM_Q;
    logic                   DRAM_valid;

    modport master (
        output DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D,
        input  DRAM_Q, DRAM_valid
    );

    modport slave (
        input  DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D,
        output DRAM_Q, DRAM_valid
    );
endinterface

// File: rtl/dram_device_model.sv
// Single-bank cycle-accurate SDRAM model: command decode, open-row state with
// tRCD/tRP checks, byte-masked writes and a fixed CAS-latency read pipeline.
module dram_device_model #(
    parameter int ROW_BITS  = 11,
    parameter int COL_BITS  = 10,
    parameter int DATA_BITS = 32,
    parameter int CAS_LAT   = 5,
    parameter int T_RCD     = 5,
    parameter int T_RP      = 5
) (
    input  logic               clk,
    input  logic               rst,
    dram_device_model_if.slave dram,
    output logic               row_open,
    output logic               cmd_err
);
    localparam int NB    = DATA_BITS / 8;
    localparam int AW    = ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << AW;
    localparam int RCD_W = $clog2(T_RCD + 2);
    localparam int RP_W  = $clog2(T_RP + 2);

    typedef enum logic {IDLE, ACTIVE} bank_state_t;
    typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_PRE, CMD_READ, CMD_WRITE, CMD_BAD} cmd_t;

    bank_state_t          state, next_state;
    cmd_t                 cmd;
    logic [ROW_BITS-1:0]  row;
    logic [RCD_W-1:0]     rcd_cnt;
    logic [RP_W-1:0]      rp_cnt;
    logic                 rcd_ok, rp_ok;
    logic                 do_act, do_pre, do_rd, do_wr, err_set;
    logic [AW-1:0]        word_addr;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [DATA_BITS-1:0] rd_word;
    logic [DATA_BITS-1:0] pipe_d [CAS_LAT];
    logic [CAS_LAT-1:0]   pipe_v;

    always_comb begin
        cmd = CMD_NOP;
        if (!dram.DRAM_CSn) begin
            case ({dram.DRAM_RASn, dram.DRAM_CASn})
                2'b00:   cmd = CMD_BAD;
                2'b01: begin
                    if (&dram.DRAM_WEn)       cmd = CMD_ACT;
                    else if (~|dram.DRAM_WEn) cmd = CMD_PRE;
                    else                      cmd = CMD_BAD;
                end
                2'b10:   cmd = (&dram.DRAM_WEn) ? CMD_READ : CMD_WRITE;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    // Counters hold cycles elapsed since the last ACT/PRE edge, saturating at the limit.
    assign rcd_ok = (rcd_cnt >= RCD_W'(T_RCD));
    assign rp_ok  = (rp_cnt >= RP_W'(T_RP));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        do_act     = 1'b0;
        do_pre     = 1'b0;
        do_rd      = 1'b0;
        do_wr      = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                case (cmd)
                    CMD_ACT: begin
                        if (rp_ok) begin
                            next_state = ACTIVE;
                            do_act     = 1'b1;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                    CMD_READ, CMD_WRITE, CMD_BAD: err_set = 1'b1;
                    default: ;
                endcase
            end
            ACTIVE: begin
                case (cmd)
                    CMD_ACT, CMD_BAD: err_set = 1'b1;
                    CMD_PRE: begin
                        next_state = IDLE;
                        do_pre     = 1'b1;
                    end
                    CMD_READ: begin
                        if (rcd_ok) do_rd = 1'b1;
                        else        err_set = 1'b1;
                    end
                    CMD_WRITE: begin
                        if (rcd_ok) do_wr = 1'b1;
                        else        err_set = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcd_cnt <= RCD_W'(T_RCD);
            rp_cnt  <= RP_W'(T_RP);
            row     <= '0;
            cmd_err <= 1'b0;
        end else begin
            if (do_act)                     rcd_cnt <= RCD_W'(1);
            else if (rcd_cnt < RCD_W'(T_RCD)) rcd_cnt <= rcd_cnt + RCD_W'(1);
            if (do_pre)                     rp_cnt <= RP_W'(1);
            else if (rp_cnt < RP_W'(T_RP))  rp_cnt <= rp_cnt + RP_W'(1);
            if (do_act)  row     <= dram.DRAM_A[ROW_BITS-1:0];
            if (err_set) cmd_err <= 1'b1;
        end
    end

    assign row_open  = (state == ACTIVE);
    assign word_addr = {row, dram.DRAM_A[COL_BITS-1:0]};
    assign rd_word   = mem[word_addr];

    // Array contents survive reset, so this block has no reset branch.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (!dram.DRAM_WEn[b]) mem[word_addr][b*8 +: 8] <= dram.DRAM_D[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_v          <= '0;
            dram.DRAM_valid <= 1'b0;
            dram.DRAM_Q     <= '0;
            for (int unsigned i = 0; i < CAS_LAT; i++) pipe_d[i] <= '0;
        end else begin
            pipe_v[0] <= do_rd;
            pipe_d[0] <= rd_word;
            for (int unsigned i = 1; i < CAS_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
            // Final register stage lands the strobe exactly CAS_LAT edges after READ.
            dram.DRAM_valid <= pipe_v[CAS_LAT-1];
            if (pipe_v[CAS_LAT-1]) dram.DRAM_Q <= pipe_d[CAS_LAT-1];
        end
    end
endmodule

// File: doc/dram_device_model.md
Name: dram_device_model

Overview:
- Single-bank, cycle-accurate SDRAM device model that sits directly downstream of the AXI-to-DRAM wrapper.
- Decodes the wrapper's raw command pins (CSn/RASn/CASn/WEn/A/D) each clock.
- Holds an open-row state with activation and precharge timing checks.
- Returns read data through a fixed CAS-latency pipeline on DRAM_Q/DRAM_valid.

Parameters:
- ROW_BITS, 11, row address width (taken from A[ROW_BITS-1:0] on ACT).
- COL_BITS, 10, column address width (taken from A[COL_BITS-1:0] on READ/WRITE).
- DATA_BITS, 32, word width; byte lanes = DATA_BITS/8.
- CAS_LAT, 5, cycles from READ command edge to DRAM_valid.
- T_RCD, 5, minimum cycles from ACT to the first READ/WRITE.
- T_RP, 5, minimum cycles from PRE to the next ACT.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset; asynchronous, active-low.
- DRAM_CSn  in  1  chip select, active-low; when 1 the command is NOP.
- DRAM_RASn  in  1  row strobe, active-low.
- DRAM_CASn  in  1  column strobe, active-low.
- DRAM_WEn  in  DATA_BITS/8  per-byte write enable, active-low.
- DRAM_A  in  11  row or column address.
- DRAM_D  in  DATA_BITS  write data.
- DRAM_Q  out  DATA_BITS  read data.
- DRAM_valid  out  1  DRAM_Q valid strobe, one cycle per READ.
- row_open  out  1  status: a row is currently active.
- cmd_err  out  1  sticky: an illegal or early command was seen.

Behaviour:
- Reset (rst=0, async):
  - DRAM_Q=0, DRAM_valid=0, row_open=0, cmd_err=0.
  - Latency pipeline flushed; timing counters saturated (no pending constraint).
  - Memory array contents are not reset.
  - Reset asserted mid-read drops the pending valid; no DRAM_valid appears after release.
- Command decode, sampled at posedge when CSn=0:
  - ACT: RASn=0, CASn=1, WEn=all 1.
  - PRE: RASn=0, CASn=1, WEn=all 0.
  - READ: RASn=1, CASn=0, WEn=all 1.
  - WRITE: RASn=1, CASn=0, any WEn bit 0.
  - NOP: RASn=1 and CASn=1, or CSn=1.
  - Any other encoding (RASn=0 and CASn=0, or PRE with mixed WEn) is ignored and sets cmd_err.
- Bank states: IDLE, ACTIVE.
  - IDLE + ACT (T_RP satisfied) -> ACTIVE; latch row=A[ROW_BITS-1:0]; row_open=1 the next cycle; restart the RCD counter.
  - ACTIVE + PRE -> IDLE; row_open=0 the next cycle; restart the RP counter.
  - PRE in IDLE is a legal NOP.
  - ACT in ACTIVE, READ/WRITE in IDLE, READ/WRITE before T_RCD cycles, and ACT before T_RP cycles: command ignored, cmd_err set.
- RCD/RP counters:
  - A READ/WRITE exactly T_RCD cycles after the ACT edge is legal.
  - Counter saturates; it does not wrap.
- WRITE:
  - Array word {row, A[COL_BITS-1:0]} is updated at the command edge.
  - Only bytes whose WEn bit is 0 are written.
- READ:
  - The word is read at the command edge and pushed into a CAS_LAT-deep shift pipeline.
  - DRAM_valid=1 exactly CAS_LAT cycles after that edge, for 1 cycle, with DRAM_Q=the word.
  - Back-to-back READs on consecutive cycles each produce their own valid on consecutive cycles.
  - A WRITE to the same address after a READ does not alter the already-captured read data.
  - DRAM_Q holds its last value when DRAM_valid=0.
- PRE issued while reads are still in the pipeline: the pending data is still delivered.
- cmd_err clears only on reset.
- Address width: addresses are zero-extended into a 2^(ROW_BITS+COL_BITS)-word array; no wrap across rows.

Test Plan:
- Reset, then ACT row 0x003 @t0, WRITE col 0x010 D=0xDEADBEEF WEn=0000 @t0+5, PRE, ACT 0x003, READ col 0x010 @tR -> DRAM_valid=1 at tR+5 only, DRAM_Q=0xDEADBEEF, cmd_err=0.
- Byte strobes: word 0x11223344 already stored, WRITE D=0xAABBCCDD WEn=1010 -> subsequent READ returns 0x11BB33DD.
- Burst: 4 READs on consecutive cycles to cols 0..3 holding 0xA0..0xA3 -> valid high for 4 consecutive cycles starting 5 cycles after the first READ, data in order.
- Timing violation: READ 3 cycles after ACT -> no DRAM_valid, cmd_err=1; ACT 2 cycles after PRE -> row_open stays 0.
- READ col 0x020 (holding 0x5) then WRITE col 0x020 D=0x9 next cycle -> valid returns 0x5; a later READ returns 0x9.
- rst pulsed low 2 cycles after a READ -> DRAM_valid never asserts, row_open=0, memory retains prior contents on re-ACT/READ.
